multicycle_core: RTL and testbench

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/multicycle_core_if.sv | 27 ++
 rtl/multicycle_core.sv | 145 ++++++++++++++
 tb/tb_multicycle_core.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_core_if.sv
// Instruction- and data-memory request/ack bundle for multicycle_core.
// The core drives requests through the master modport; memories sit on the slave side.
interface multicycle_core_if #(
   parameter int XLEN = 64
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic            imem_ack;
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_ack;

   // Handshake: a request stays high with address/data stable until the clock edge
   // where ack=1 completes it; ack seen while the matching request is low is ignored.
   modport master (
      output imem_req, imem_addr, input imem_rdata, imem_ack,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ack
   );
   modport slave (
      input imem_req, imem_addr, output imem_rdata, imem_ack,
      input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/multicycle_core.sv
// Multicycle LEGv8-subset core: FETCH/DECODE/EXEC/MEM/WB FSM over word-addressed memories.
// Define MULTICYCLE_CORE_RETIRE_CNT_EN to build the retired-instruction counter.
module multicycle_core #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   multicycle_core_if.master   bus,
   output logic [2:0]          state_o,
   output logic                halted,
   output logic [31:0]         retired
);
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   logic [2:0]      state;
   logic [XLEN-1:0] pc, a, b, res;
   logic [31:0]     ir;
   logic [XLEN-1:0] regs [32];

   logic [10:0] op11;
   logic        is_add, is_sub, is_and, is_orr, is_rtype;
   logic        is_ldur, is_stur, is_cbz, is_b, supported;
   logic [XLEN-1:0] rn_val, rm_val, rt_val, imm_d, off_cb, off_b, alu_res;
   logic        unused_ir_bits;

   assign op11      = ir[31:21];
   assign is_add    = (op11 == 11'b10001011000);
   assign is_sub    = (op11 == 11'b11001011000);
   assign is_and    = (op11 == 11'b10001010000);
   assign is_orr    = (op11 == 11'b10101010000);
   assign is_ldur   = (op11 == 11'b11111000010);
   assign is_stur   = (op11 == 11'b11111000000);
   assign is_cbz    = (ir[31:24] == 8'b10110100);
   assign is_b      = (ir[31:26] == 6'b000101);
   assign is_rtype  = is_add | is_sub | is_and | is_orr;
   assign supported = is_rtype | is_ldur | is_stur | is_cbz | is_b;
   assign unused_ir_bits = ^ir[11:10];

   // X31 is the zero register: reads return 0, writes are dropped in WB.
   assign rn_val = (ir[9:5]   == 5'd31) ? '0 : regs[ir[9:5]];
   assign rm_val = (ir[20:16] == 5'd31) ? '0 : regs[ir[20:16]];
   assign rt_val = (ir[4:0]   == 5'd31) ? '0 : regs[ir[4:0]];

   assign imm_d  = {{(XLEN-9){ir[20]}},  ir[20:12]};
   assign off_cb = {{(XLEN-19){ir[23]}}, ir[23:5]};
   assign off_b  = {{(XLEN-26){ir[25]}}, ir[25:0]};

   always_comb begin
      alu_res = '0;
      if (is_add)      alu_res = a + b;
      else if (is_sub) alu_res = a - b;
      else if (is_and) alu_res = a & b;
      else if (is_orr) alu_res = a | b;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         ir    <= '0;
         a     <= '0;
         b     <= '0;
         res   <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (bus.imem_ack) begin
                  ir    <= bus.imem_rdata;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               a     <= rn_val;
               b     <= is_rtype ? rm_val : rt_val;
               state <= supported ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
               if (is_rtype) begin
                  res   <= alu_res;
                  state <= S_WB;
               end else if (is_ldur || is_stur) begin
                  res   <= a + imm_d;
                  state <= S_MEM;
               end else if (is_cbz) begin
                  pc    <= (b == '0) ? pc + off_cb : pc + XLEN'(1);
                  state <= S_FETCH;
               end else begin
                  pc    <= pc + off_b;
                  state <= S_FETCH;
               end
            end
            S_MEM: begin
               // res holds the address until the access completes, then the load data
               if (bus.dmem_ack) begin
                  if (is_stur) begin
                     pc    <= pc + XLEN'(1);
                     state <= S_FETCH;
                  end else begin
                     res   <= bus.dmem_rdata;
                     state <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (ir[4:0] != 5'd31) regs[ir[4:0]] <= res;
               pc    <= pc + XLEN'(1);
               state <= S_FETCH;
            end
            S_HALT: state <= S_HALT;
            default: state <= S_HALT;
         endcase
      end
   end

   assign bus.imem_req   = rst && (state == S_FETCH);
   assign bus.imem_addr  = pc;
   assign bus.dmem_req   = rst && (state == S_MEM);
   assign bus.dmem_we    = (state == S_MEM) && is_stur;
   assign bus.dmem_addr  = res;
   assign bus.dmem_wdata = b;
   assign state_o        = state;
   assign halted         = (state == S_HALT);

`ifdef MULTICYCLE_CORE_RETIRE_CNT_EN
   logic [31:0] retire_cnt;
   logic        retire_now;
   assign retire_now = (state == S_EXEC && (is_cbz || is_b))
                    || (state == S_MEM && bus.dmem_ack && is_stur)
                    || (state == S_WB);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            retire_cnt <= '0;
      else if (retire_now) retire_cnt <= retire_cnt + 32'd1;
   end
   assign retired = retire_cnt;
`else
   assign retired = '0;
`endif
endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: directed programs, memory responders, expected queues.
// Expected retired counts follow MULTICYCLE_CORE_RETIRE_CNT_EN.
module tb_multicycle_core;
   localparam int XLEN = 64;
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
`ifdef MULTICYCLE_CORE_RETIRE_CNT_EN
   localparam int EXP_RET1 = 25;
   localparam int EXP_RET2 = 6;
`else
   localparam int EXP_RET1 = 0;
   localparam int EXP_RET2 = 0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   multicycle_core_if #(.XLEN(XLEN)) bus ();
   logic [2:0]  state_o;
   logic        halted;
   logic [31:0] retired;

   multicycle_core #(.XLEN(XLEN), .RESET_PC('0)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .state_o(state_o), .halted(halted), .retired(retired)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0]     imem [int];
   logic [XLEN-1:0] dmem [longint unsigned];
   logic [XLEN-1:0] exp_fetch_q[$];
   int              exp_gap_q[$];
   logic [2*XLEN:0] exp_dmem_q[$];
   int  prev_lat   = 0;
   int  first_wait = -1;
   int  max_wait   = 0;
   bit  noise_en   = 0;
   bit  dmem_hold  = 0;
   bit  gap_check  = 0;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input logic [XLEN-1:0] act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %h, expected no transaction", name, act);
   endtask

   function automatic logic [31:0] rt(input logic [10:0] op, input logic [4:0] rd, input logic [4:0] rn,
                                      input logic [4:0] rm);
      return {op, rm, 6'b0, rn, rd};
   endfunction
   function automatic logic [31:0] dt(input logic [10:0] op, input logic [4:0] rtr, input logic [4:0] rn,
                                      input logic [8:0] imm);
      return {op, imm, 2'b00, rn, rtr};
   endfunction
   function automatic logic [31:0] cbz(input logic [4:0] rtr, input logic [18:0] imm);
      return {8'b10110100, imm, rtr};
   endfunction
   function automatic logic [31:0] br(input logic [25:0] imm);
      return {6'b000101, imm};
   endfunction

   // driver tasks: place an instruction and push its expected fetch (and gap since previous fetch)
   task automatic ins(input int addr, input logic [31:0] instr, input int lat);
      imem[addr] = instr;
      exp_fetch_q.push_back(XLEN'(addr));
      exp_gap_q.push_back(prev_lat);
      prev_lat = lat;
   endtask
   task automatic exp_ld(input logic [XLEN-1:0] addr);
      exp_dmem_q.push_back({1'b0, addr, {XLEN{1'b0}}});
   endtask
   task automatic exp_st(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data);
      exp_dmem_q.push_back({1'b1, addr, data});
   endtask
   task automatic flush_q();
      exp_fetch_q.delete();
      exp_gap_q.delete();
      exp_dmem_q.delete();
      imem.delete();
      prev_lat = 0;
   endtask

   task automatic load_prog1();
      flush_q();
      dmem[0] = 64'd5; dmem[8] = 64'd7; dmem[128] = 64'h100; dmem[136] = 64'hDEAD;
      ins(0,  dt(OP_LDUR, 1, 31, 9'd0), 5);    exp_ld(64'd0);
      ins(1,  dt(OP_LDUR, 2, 31, 9'd8), 5);    exp_ld(64'd8);
      ins(2,  rt(OP_ADD, 3, 1, 2), 4);
      ins(3,  dt(OP_STUR, 3, 31, 9'd16), 4);   exp_st(64'd16, 64'd12);
      ins(4,  rt(OP_SUB, 4, 2, 1), 4);
      ins(5,  dt(OP_STUR, 4, 31, 9'd24), 4);   exp_st(64'd24, 64'd2);
      ins(6,  rt(OP_AND, 5, 1, 2), 4);
      ins(7,  dt(OP_STUR, 5, 31, 9'd32), 4);   exp_st(64'd32, 64'd5);
      ins(8,  rt(OP_ORR, 6, 1, 2), 4);
      ins(9,  dt(OP_STUR, 6, 31, 9'd40), 4);   exp_st(64'd40, 64'd7);
      ins(10, rt(OP_SUB, 7, 1, 2), 4);
      ins(11, dt(OP_STUR, 7, 31, 9'd56), 4);   exp_st(64'd56, 64'hFFFF_FFFF_FFFF_FFFE);
      ins(12, dt(OP_LDUR, 8, 31, 9'd128), 5);  exp_ld(64'd128);
      ins(13, dt(OP_LDUR, 9, 31, 9'd136), 5);  exp_ld(64'd136);
      ins(14, dt(OP_STUR, 9, 8, 9'd8), 4);     exp_st(64'h108, 64'hDEAD);
      ins(15, dt(OP_LDUR, 10, 8, 9'd8), 5);    exp_ld(64'h108);
      ins(16, dt(OP_STUR, 10, 31, 9'd64), 4);  exp_st(64'd64, 64'hDEAD);
      ins(17, dt(OP_STUR, 9, 8, 9'h1F8), 4);   exp_st(64'hF8, 64'hDEAD);
      ins(18, rt(OP_ADD, 31, 1, 2), 4);
      ins(19, rt(OP_ADD, 11, 31, 31), 4);
      ins(20, dt(OP_STUR, 11, 31, 9'd72), 4);  exp_st(64'd72, 64'd0);
      ins(21, cbz(5'd11, 19'd3), 3);
      ins(24, cbz(5'd1, 19'd5), 3);
      ins(25, br(26'd2), 3);
      ins(27, dt(OP_STUR, 1, 31, 9'd80), 4);   exp_st(64'd80, 64'd5);
      ins(28, 32'h0000_0000, 0);
   endtask

   task automatic load_prog2();
      flush_q();
      dmem[0] = 64'd5;
      ins(0,  br(26'd10), 3);
      ins(10, cbz(5'd5, 19'h7FFFE), 3);
      ins(8,  dt(OP_LDUR, 5, 31, 9'd0), 5);    exp_ld(64'd0);
      ins(9,  br(26'd1), 3);
      ins(10, cbz(5'd5, 19'h7FFFE), 3);
      ins(11, dt(OP_STUR, 5, 31, 9'd24), 4);   exp_st(64'd24, 64'd5);
      ins(12, 32'h0000_0000, 0);
   endtask

   task automatic wait_halt(input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("halt_reached", XLEN'(halted), XLEN'(1));
   endtask

   // memory responders: decide ack just after each rising edge
   initial begin
      int iw = -1;
      int dw = -1;
      bus.imem_ack = 1'b0; bus.imem_rdata = '0;
      bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
            iw = -1; dw = -1;
         end else begin
            if (bus.imem_req) begin
               if (iw < 0) begin
                  if (first_wait >= 0) begin iw = first_wait; first_wait = -1; end
                  else iw = $urandom_range(0, max_wait);
               end
               if (iw == 0) begin
                  bus.imem_ack   = 1'b1;
                  bus.imem_rdata = imem.exists(int'(bus.imem_addr)) ? imem[int'(bus.imem_addr)] : 32'h0;
                  iw = -1;
               end else begin
                  bus.imem_ack = 1'b0;
                  iw--;
               end
            end else begin
               bus.imem_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
               bus.imem_rdata = $urandom;
            end
            if (bus.dmem_req && !dmem_hold) begin
               if (dw < 0) dw = $urandom_range(0, max_wait);
               if (dw == 0) begin
                  bus.dmem_ack = 1'b1;
                  if (bus.dmem_we) begin
                     dmem[bus.dmem_addr] = bus.dmem_wdata;
                     bus.dmem_rdata = {$urandom, $urandom};
                  end else begin
                     bus.dmem_rdata = dmem.exists(bus.dmem_addr) ? dmem[bus.dmem_addr] : '0;
                  end
                  dw = -1;
               end else begin
                  bus.dmem_ack = 1'b0;
                  dw--;
               end
            end else begin
               bus.dmem_ack   = (noise_en && !bus.dmem_req) ? 1'($urandom_range(0, 1)) : 1'b0;
               bus.dmem_rdata = {$urandom, $urandom};
            end
         end
      end
   end

   // scoreboard monitor: pops expectations on each completed handshake
   int              cyc = 0;
   int              last_fetch = 0;
   bit              i_stall = 0, d_stall = 0;
   logic [XLEN-1:0] i_addr_q, e_fetch;
   logic [2*XLEN:0] d_q, e_dmem;
   int              e_gap;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         check("req_exclusive", XLEN'(bus.imem_req & bus.dmem_req), '0);
         if (halted) check("halt_no_req", XLEN'({bus.imem_req, bus.dmem_req}), '0);
         if (bus.imem_req) begin
            check("fetch_state", XLEN'(state_o), XLEN'(0));
            if (i_stall) check("imem_addr_stable", bus.imem_addr, i_addr_q);
            if (bus.imem_ack) begin
               if (exp_fetch_q.size() == 0) flag("unexpected_fetch", bus.imem_addr);
               else begin
                  e_fetch = exp_fetch_q.pop_front();
                  e_gap   = exp_gap_q.pop_front();
                  check("fetch_addr", bus.imem_addr, e_fetch);
                  if (gap_check && e_gap > 0) check("fetch_gap", XLEN'(cyc - last_fetch), XLEN'(e_gap));
               end
               last_fetch = cyc;
            end
         end
         i_stall  = bus.imem_req && !bus.imem_ack;
         i_addr_q = bus.imem_addr;
         if (bus.dmem_req) begin
            if (d_stall) check("dmem_stable", XLEN'(d_q != {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}), '0);
            if (bus.dmem_ack) begin
               if (exp_dmem_q.size() == 0) flag("unexpected_dmem", bus.dmem_addr);
               else begin
                  e_dmem = exp_dmem_q.pop_front();
                  check("dmem_we", XLEN'(bus.dmem_we), XLEN'(e_dmem[2*XLEN]));
                  check("dmem_addr", bus.dmem_addr, e_dmem[2*XLEN-1:XLEN]);
                  if (e_dmem[2*XLEN]) check("dmem_wdata", bus.dmem_wdata, e_dmem[XLEN-1:0]);
               end
            end
         end
         d_stall = bus.dmem_req && !bus.dmem_ack;
         d_q     = {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata};
      end else begin
         i_stall = 1'b0;
         d_stall = 1'b0;
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_state"},   XLEN'(state_o), XLEN'(0));
      check({tag, "_halted"},  XLEN'(halted), '0);
      check({tag, "_retired"}, XLEN'(retired), '0);
      check({tag, "_imem_req"}, XLEN'(bus.imem_req), '0);
      check({tag, "_dmem_req"}, XLEN'(bus.dmem_req), '0);
   endtask

   task automatic release_and_check_fetch();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_reset_imem_req", XLEN'(bus.imem_req), XLEN'(1));
      check("post_reset_imem_addr", bus.imem_addr, '0);
   endtask

   task automatic finish_run(input int exp_ret);
      wait_halt(3000);
      check("halt_state", XLEN'(state_o), XLEN'(5));
      repeat (10) @(negedge clk);
      check("halt_state_held", XLEN'(state_o), XLEN'(5));
      check("retired", XLEN'(retired), XLEN'(exp_ret));
      check("fetch_q_empty", XLEN'(exp_fetch_q.size()), '0);
      check("dmem_q_empty", XLEN'(exp_dmem_q.size()), '0);
   endtask

   initial begin
      // phase A: full ISA program, immediate acks, latency checked
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      gap_check = 1; max_wait = 0; noise_en = 0;
      load_prog1();
      release_and_check_fetch();
      finish_run(EXP_RET1);

      // phase B: branches, 6-cycle first fetch stall, random waits, stray acks
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_state("reset_b");
      gap_check = 0; max_wait = 3; noise_en = 1; first_wait = 6;
      load_prog2();
      release_and_check_fetch();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("stall_state", XLEN'(state_o), XLEN'(0));
         check("stall_imem_req", XLEN'(bus.imem_req), XLEN'(1));
         check("stall_imem_addr", bus.imem_addr, '0);
      end
      finish_run(EXP_RET2);

      // phase C: reset asserted while a load is outstanding
      @(negedge clk);
      rst = 1'b0;
      gap_check = 0; max_wait = 0; noise_en = 0; dmem_hold = 1;
      load_prog2();
      @(negedge clk);
      rst = 1'b1;
      begin
         int n = 0;
         while (!bus.dmem_req && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      check("mem_pending", XLEN'(bus.dmem_req), XLEN'(1));
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_reset_state("reset_mid_mem");
      dmem_hold = 0; gap_check = 1;
      load_prog2();
      repeat (2) @(posedge clk);
      release_and_check_fetch();
      finish_run(EXP_RET2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
